ahb_ext_responder: RTL and testbench
====================================

# ahb_ext_responder

Parametrised AHB-Lite subordinate that replaces fixed tie-offs of the SoC external bus port (HREADYEXT/HRESPEXT/HRDATAEXT) in lint and simulation harnesses. It provides a word-addressed backing RAM, a per-transfer programmable wait-state count, and an optional address window that returns the two-cycle AHB ERROR response. It sits beside wallypipelinedsoc in the testbench and connects to HSELEXT and the shared AHB signals.

## Interface
- AHBW, 64, data bus width in bits (32 or 64)
- PA_BITS, 34, physical address width
- DEPTH, 256, RAM depth in AHBW-bit words (power of two)
- ERR_BASE, 'h0, first byte address of error window
- ERR_SIZE, 'h0, byte size of error window (0 = none)

- HCLK  input  1  bus clock; all state changes on rising edge
- HRESETn  input  1  synchronous active-low reset
- HSEL  input  1  subordinate select (tie to HSELEXT)
- HADDR  input  PA_BITS  transfer address
- HWRITE  input  1  1 = write
- HSIZE  input  3  transfer size (informational; byte lanes come from HWSTRB)
- HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ
- HREADY  input  1  bus-wide ready (previous transfer complete)
- HWDATA  input  AHBW  write data, valid in data phase
- HWSTRB  input  AHBW/8  byte-lane write enables, valid in data phase
- WaitCycles  input  4  wait states inserted for the next accepted transfer
- HREADYOUT  output  1  data phase complete
- HRESP  output  1  0 = OKAY, 1 = ERROR
- HRDATA  output  AHBW  read data

## Operation
- Address phase accepted when HSEL & HTRANS[1] & HREADY; registers word index, HWRITE, error-hit flag, and WaitCycles into counter.
- Word index = HADDR[$clog2(AHBW/8) +: $clog2(DEPTH)]; upper bits ignored (aliases modulo DEPTH).
- Error hit = ERR_BASE <= HADDR < ERR_BASE+ERR_SIZE, evaluated on full PA_BITS address.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On accept: counter>0 -> WAIT; counter=0 and hit -> ERR1; counter=0, no hit -> completes data phase in the next cycle (DATA substate of IDLE with OKAY, HREADYOUT=1).
  - WAIT: HREADYOUT=0, HRESP=0, counter decrements; at counter=1 -> ERR1 if hit else final OKAY cycle.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; new address phase may be accepted this cycle -> next state per new transfer, else IDLE.
- Final OKAY cycle: write commits HWDATA to RAM per HWSTRB at the clock edge ending the cycle; read drives HRDATA = RAM[index].
- HRDATA = 0 in all cycles except a completing OKAY read.
- Error transfers never write RAM.
- IDLE/BUSY transfers or HSEL=0: no state change; zero-wait OKAY.
- RAM contents not reset; undefined until written.

## Timing
- Reset (HRESETn=0 at edge): state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0; any pending write discarded, mid-wait or mid-error transfer abandoned.
- Latency: data phase lasts WaitCycles+1 cycles for OKAY; WaitCycles+2 for ERROR.
- WaitCycles sampled only at address acceptance; changes during a data phase have no effect.
- Pipelined back-to-back: next address phase accepted in the completing cycle; read of an address written by the immediately preceding transfer returns the new data.
- Simultaneous write completion and new accept of the same index: write commits, following read sees it.

## Configuration
- AHB_EXT_RESPONDER_ERRINJ_EN defined: error window decoding and ERR1/ERR2 states present.
- Undefined: ERR_BASE/ERR_SIZE ignored, hit forced 0, HRESP constant 0, ERR states removed.

## Test plan
- Reset with HRESETn=0 two cycles mid-WAIT (WaitCycles=5) -> HREADYOUT=1, HRESP=0, HRDATA=0 next cycle; pending write to index 3 not committed.
- Zero-wait write 'h1122334455667788 to 'h80 with HWSTRB='hFF, then read 'h80 back-to-back -> HREADYOUT always 1, HRDATA='h1122334455667788 in the read data phase.
- Partial write HWSTRB='h0F of 'hAAAAAAAAAAAAAAAA over 'h1122334455667788 -> readback 'h11223344AAAAAAAA.
- WaitCycles=3 read -> HREADYOUT low exactly 3 cycles, data valid on 4th; WaitCycles changed to 0 during wait has no effect.
- With ERRINJ_EN, ERR_BASE='h1000, ERR_SIZE='h100: write to 'h1008 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, RAM alias index unchanged; access to 'h1100 -> OKAY.
- Address 'h800 with DEPTH=256, AHBW=64 -> aliases index 0; write then read 'h0 returns same data.

Source files
------------

// File: rtl/ahb_ext_responder_if.sv
// ahb_ext_responder_if: AHB-Lite signal bundle between the bus master side and the external-port responder
interface ahb_ext_responder_if #(
  parameter int AHBW = 64,
  parameter int PA_BITS = 34
);
  logic HSEL;
  logic [PA_BITS-1:0] HADDR;
  logic HWRITE;
  logic [2:0] HSIZE;
  logic [1:0] HTRANS;
  logic HREADY;
  logic [AHBW-1:0] HWDATA;
  logic [AHBW/8-1:0] HWSTRB;
  logic [3:0] WaitCycles;
  logic HREADYOUT;
  logic HRESP;
  logic [AHBW-1:0] HRDATA;
  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, HWSTRB, WaitCycles,
    input HREADYOUT, HRESP, HRDATA
  );
  modport slave (
    input HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, HWSTRB, WaitCycles,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_ext_responder.sv
// ahb_ext_responder: AHB-Lite subordinate with word RAM and per-transfer wait states;
// define AHB_EXT_RESPONDER_ERRINJ_EN to enable the two-cycle ERROR address window.
module ahb_ext_responder #(
  parameter int AHBW = 64,
  parameter int PA_BITS = 34,
  parameter int DEPTH = 256,
  parameter logic [PA_BITS-1:0] ERR_BASE = '0,
  parameter logic [PA_BITS-1:0] ERR_SIZE = '0
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_ext_responder_if.slave bus
);
  localparam int OFF = $clog2(AHBW/8);
  localparam int IW = $clog2(DEPTH);
  logic w_acc, w_hit, w_unused;
  logic [IW-1:0] w_idx;
`ifdef AHB_EXT_RESPONDER_ERRINJ_EN
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  localparam state_t ERR_ST = ERR1;
  localparam logic [PA_BITS:0] ERR_END = {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};
  assign w_hit = (bus.HADDR >= ERR_BASE) && ({1'b0, bus.HADDR} < ERR_END);
  assign w_unused = ^{bus.HSIZE, bus.HADDR, bus.HTRANS};
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
  localparam state_t ERR_ST = IDLE;
  assign w_hit = 1'b0;
  assign w_unused = ^{bus.HSIZE, bus.HADDR, bus.HTRANS, ERR_BASE, ERR_SIZE};
`endif
  state_t r_state;
  logic [3:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic r_wr, r_hit, r_act, r_ready, r_resp;
  logic [AHBW-1:0] r_mem [DEPTH];
  assign w_acc = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
  assign w_idx = bus.HADDR[OFF +: IW];
  // r_act marks the completing OKAY data-phase cycle (the DATA substate of IDLE)
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_wr <= 1'b0;
      r_hit <= 1'b0;
      r_act <= 1'b0;
      r_ready <= 1'b1;
      r_resp <= 1'b0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_state <= r_hit ? ERR_ST : IDLE;
        r_act <= !r_hit;
        r_ready <= !r_hit;
        r_resp <= r_hit;
      end
`ifdef AHB_EXT_RESPONDER_ERRINJ_EN
    end else if (r_state == ERR1) begin
      r_state <= ERR2;
      r_ready <= 1'b1;
`endif
    end else if (w_acc) begin
      r_idx <= w_idx;
      r_wr <= bus.HWRITE;
      r_hit <= w_hit;
      r_cnt <= bus.WaitCycles;
      r_state <= (bus.WaitCycles != 4'd0) ? WAIT : w_hit ? ERR_ST : IDLE;
      r_act <= (bus.WaitCycles == 4'd0) && !w_hit;
      r_ready <= (bus.WaitCycles == 4'd0) && !w_hit;
      r_resp <= (bus.WaitCycles == 4'd0) && w_hit;
    end else begin
      r_state <= IDLE;
      r_act <= 1'b0;
      r_ready <= 1'b1;
      r_resp <= 1'b0;
    end
  end
  // Commit happens at the edge ending the completing cycle, so a pipelined read of the same word sees it
  always_ff @(posedge HCLK) begin
    if (HRESETn && r_act && r_wr)
      for (int b = 0; b < AHBW/8; b++)
        if (bus.HWSTRB[b]) r_mem[r_idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
  end
  assign bus.HREADYOUT = r_ready;
  assign bus.HRESP = r_resp;
  assign bus.HRDATA = (r_act && !r_wr) ? r_mem[r_idx] : '0;
endmodule

// File: tb/tb_ahb_ext_responder.sv
// tb_ahb_ext_responder: scoreboard bench for ahb_ext_responder; error-window expectations follow AHB_EXT_RESPONDER_ERRINJ_EN
module tb_ahb_ext_responder;
  typedef struct {
    logic wr;
    logic err;
    logic [63:0] rdata;
    int wc;
  } sb_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int nchk = 0;
  int nfail = 0;
  int lowc = 0;
  bit mon_en = 1'b0;
  sb_t sb[$];
  logic [63:0] mdl [256];
  ahb_ext_responder_if #(.AHBW(64), .PA_BITS(34)) bus ();
  ahb_ext_responder #(
    .AHBW(64), .PA_BITS(34), .DEPTH(256), .ERR_BASE(34'h1000), .ERR_SIZE(34'h100)
  ) dut (
    .HCLK(clk),
    .HRESETn(rstn),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.HREADY = bus.HREADYOUT;
  function automatic bit hit(input logic [33:0] a);
`ifdef AHB_EXT_RESPONDER_ERRINJ_EN
    return (a >= 34'h1000) && (a < 34'h1100);
`else
    return 1'b0;
`endif
  endfunction
  // scoreboard: entries pushed at address acceptance, popped when HREADYOUT completes the data phase
  always @(negedge clk) begin : mon
    sb_t e;
    if (rstn && mon_en) begin
      if (sb.size() == 0) begin
        lowc = 0;
        nchk++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 64'h0) begin
          nfail++;
          $display("FAIL idle: ready=%b resp=%b rdata=%h, required 1 0 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
        end
      end else if (bus.HREADYOUT !== 1'b1) begin
        nchk++;
        if (bus.HRESP !== (sb[0].err && lowc == sb[0].wc) || bus.HRDATA !== 64'h0) begin
          nfail++;
          $display("FAIL wait_cycle %0d: resp=%b rdata=%h, required resp=%b rdata=0", lowc, bus.HRESP, bus.HRDATA, sb[0].err && lowc == sb[0].wc);
        end
        lowc++;
        if (lowc > 40) begin
          nfail++;
          $display("FAIL stuck: HREADYOUT low %0d cycles, required <= %0d", lowc, sb[0].wc + 1);
          void'(sb.pop_front());
          lowc = 0;
        end
      end else begin
        e = sb.pop_front();
        nchk++;
        if (bus.HRESP !== e.err || bus.HRDATA !== ((e.wr || e.err) ? 64'h0 : e.rdata) || lowc != e.wc + (e.err ? 1 : 0)) begin
          nfail++;
          $display("FAIL complete: resp=%b rdata=%h waits=%0d, required resp=%b rdata=%h waits=%0d", bus.HRESP, bus.HRDATA, lowc, e.err, (e.wr || e.err) ? 64'h0 : e.rdata, e.wc + (e.err ? 1 : 0));
        end
        lowc = 0;
      end
    end
  end
  task automatic issue(input logic [33:0] a, input bit wr, input logic [63:0] d, input logic [7:0] s, input logic [3:0] wc);
    sb_t e;
    int n;
    int ix;
    ix = int'(a[10:3]);
    e.wr = wr;
    e.err = hit(a);
    e.wc = int'(wc);
    e.rdata = mdl[ix];
    if (wr && !e.err)
      for (int b = 0; b < 8; b++)
        if (s[b]) mdl[ix][b*8 +: 8] = d[b*8 +: 8];
    @(negedge clk);
    bus.HSEL = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR = a;
    bus.HWRITE = wr;
    bus.HSIZE = 3'd3;
    bus.WaitCycles = wc;
    n = 0;
    while (bus.HREADYOUT !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (n >= 50) begin
      nfail++;
      $display("FAIL accept_timeout: HREADYOUT=%b after %0d cycles, required 1", bus.HREADYOUT, n);
    end
    @(posedge clk);
    #1;
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWDATA = d;
    bus.HWSTRB = s;
    sb.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    nchk++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d transfers outstanding, required 0", sb.size());
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    nchk++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 64'h0) begin
      nfail++;
      $display("FAIL reset_state: ready=%b resp=%b rdata=%h, required 1 0 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    issue(34'h18, 1'b1, 64'h0A0A0A0A0A0A0A0A, 8'hFF, 4'd0);
    drain();
    issue(34'h18, 1'b1, 64'h0B0B0B0B0B0B0B0B, 8'hFF, 4'd5);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    mon_en = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(negedge clk);
    nchk++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 64'h0) begin
      nfail++;
      $display("FAIL reset_midwait: ready=%b resp=%b rdata=%h, required 1 0 0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    mon_en = 1'b1;
    mdl[3] = 64'h0A0A0A0A0A0A0A0A;
    issue(34'h18, 1'b0, 64'h0, 8'h00, 4'd0);
    drain();
  endtask
  task automatic test_zero_wait();
    issue(34'h80, 1'b1, 64'h1122334455667788, 8'hFF, 4'd0);
    issue(34'h80, 1'b0, 64'h0, 8'h00, 4'd0);
    drain();
  endtask
  task automatic test_partial();
    issue(34'h80, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 4'd0);
    issue(34'h80, 1'b0, 64'h0, 8'h00, 4'd0);
    drain();
  endtask
  task automatic test_wait();
    int low = 0;
    issue(34'h80, 1'b0, 64'h0, 8'h00, 4'd3);
    bus.WaitCycles = 4'd0;
    @(negedge clk);
    while (bus.HREADYOUT !== 1'b1 && low < 20) begin
      low++;
      @(negedge clk);
    end
    nchk++;
    if (low != 3 || bus.HRDATA !== 64'h11223344AAAAAAAA) begin
      nfail++;
      $display("FAIL wait3_read: low=%0d rdata=%h, required low=3 rdata=11223344aaaaaaaa", low, bus.HRDATA);
    end
    drain();
  endtask
  task automatic test_error();
    issue(34'h8, 1'b1, 64'h0123456789ABCDEF, 8'hFF, 4'd0);
    issue(34'h1008, 1'b1, 64'hDEADBEEFDEADBEEF, 8'hFF, 4'd0);
    issue(34'h8, 1'b0, 64'h0, 8'h00, 4'd0);
    issue(34'hFF8, 1'b1, 64'h5555666677778888, 8'hFF, 4'd1);
    issue(34'h10F8, 1'b1, 64'h9999999999999999, 8'hFF, 4'd2);
    issue(34'hFF8, 1'b0, 64'h0, 8'h00, 4'd0);
    issue(34'h1100, 1'b1, 64'hCAFEF00DCAFEF00D, 8'hFF, 4'd0);
    issue(34'h1100, 1'b0, 64'h0, 8'h00, 4'd1);
    drain();
  endtask
  task automatic test_alias();
    issue(34'h800, 1'b1, 64'h0F1E2D3C4B5A6978, 8'hFF, 4'd0);
    issue(34'h0, 1'b0, 64'h0, 8'h00, 4'd0);
    drain();
  endtask
  task automatic test_back_to_back();
    logic [33:0] a;
    for (int i = 0; i < 16; i++)
      issue(34'h100 + 34'(i * 8), 1'b1, {$urandom, $urandom}, 8'hFF, 4'($urandom_range(0, 2)));
    for (int i = 0; i < 40; i++) begin
      a = 34'h100 + 34'($urandom_range(0, 15) * 8) + 34'($urandom_range(0, 3) << 11);
      if ($urandom_range(0, 1) == 1) begin
        issue(a, 1'b1, {$urandom, $urandom}, 8'($urandom_range(1, 255)), 4'($urandom_range(0, 3)));
        issue(a, 1'b0, 64'h0, 8'h00, 4'd0);
      end else begin
        issue(a, 1'b0, 64'h0, 8'h00, 4'($urandom_range(0, 3)));
      end
    end
    drain();
  endtask
  initial begin
    bus.HSEL = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd3;
    bus.HWDATA = '0;
    bus.HWSTRB = '0;
    bus.WaitCycles = '0;
    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;
    mon_en = 1'b1;
    test_reset();
    test_zero_wait();
    test_partial();
    test_wait();
    test_error();
    test_alias();
    test_back_to_back();
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
